fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of a synchronous FIFO among `N_REQ` requesters. It applies packet-level locking and full/almost-full flow control. Each requester offers beats on a valid/ready handshake. The arbiter registers the winning beat onto `wr_en`/`wr_data` and, by construction, never asserts `wr_en` while `fifo_full` is high. It sits directly in front of the FIFO write interface, in place of a single hard-wired writer.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter (fifo_wr_arbiter).
package fifo_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_DW    = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // All-ones value of a cw-bit counter, used as the saturation ceiling.
    function automatic logic [31:0] CNT_SAT(input int unsigned cw);
        return (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (!any && valid[cand]) begin
                any         = 1'b1;
                idx         = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter in front of a FIFO write port.
// Optional per-requester packet counters enabled by FIFO_ARB_PERF_CNT_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW,
    parameter int CW    = 16,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_last,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                fifo_full,
    input  logic                fifo_afull,
    output logic                wr_en,
    output logic [DW-1:0]       wr_data,
    output logic [IW-1:0]       grant_id,
    output logic                busy
`ifdef FIFO_ARB_PERF_CNT_EN
    ,
    output logic [N_REQ*CW-1:0] grant_cnt
`endif
);

    if (N_REQ < 2 || N_REQ > 16 || DW < 1 || CW < 1) begin : g_param_check
        $error("fifo_wr_arbiter: parameter out of range");
    end

    arb_state_t       state, next_state;
    logic [IW-1:0]    ptr, next_ptr;
    logic [IW-1:0]    owner, next_owner;
    logic             issue_ok;
    logic             acc;
    logic [IW-1:0]    acc_idx;
    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    // A write already in flight may take the last free slot, so hold off one cycle.
    assign issue_ok = !fifo_full && !(fifo_afull && wr_en);
    assign busy     = (state == LOCK);

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_owner = owner;
        req_ready  = '0;
        acc        = 1'b0;
        acc_idx    = '0;
        unique case (state)
            ARB: begin
                if (issue_ok && pick_any) begin
                    req_ready = pick_grant;
                    acc       = 1'b1;
                    acc_idx   = pick_idx;
                    if (req_last[pick_idx]) begin
                        next_ptr = wrap_inc(pick_idx);
                    end else begin
                        next_state = LOCK;
                        next_owner = pick_idx;
                    end
                end
            end
            LOCK: begin
                if (issue_ok && req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                    acc              = 1'b1;
                    acc_idx          = owner;
                    if (req_last[owner]) begin
                        next_state = ARB;
                        next_ptr   = wrap_inc(owner);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            owner <= next_owner;
            wr_en <= acc;
            if (acc) begin
                wr_data  <= req_data[acc_idx*DW +: DW];
                grant_id <= acc_idx;
            end
        end
    end

`ifdef FIFO_ARB_PERF_CNT_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(CNT_SAT(CW));

    logic [CW-1:0] cnt [N_REQ];

    // Counts completed packets only; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (acc && req_last[acc_idx]) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_idx == IW'(i) && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CW +: CW] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// against a behavioural model. Build with FIFO_ARB_PERF_CNT_EN to also cover counters.
module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int IW    = 2;
   localparam int DEPTH = 6;
`ifdef FIFO_ARB_PERF_CNT_EN
   localparam int CW    = 2;
`else
   localparam int CW    = 16;
`endif
   localparam int SAT   = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      reqValid;
   logic [N-1:0]      reqLast;
   logic [N*DW-1:0]   reqData;
   logic [N-1:0]      reqReady;
   logic              fifoFull;
   logic              fifoAfull;
   logic              wrEn;
   logic [DW-1:0]     wrData;
   logic [IW-1:0]     grantId;
   logic              busy;
`ifdef FIFO_ARB_PERF_CNT_EN
   logic [N*CW-1:0]   grantCnt;
`endif

   fifo_wr_arbiter #(
      .N_REQ (N),
      .DW    (DW),
      .CW    (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid),
      .req_last   (reqLast),
      .req_data   (reqData),
      .req_ready  (reqReady),
      .fifo_full  (fifoFull),
      .fifo_afull (fifoAfull),
      .wr_en      (wrEn),
      .wr_data    (wrData),
      .grant_id   (grantId),
      .busy       (busy)
`ifdef FIFO_ARB_PERF_CNT_EN
      ,
      .grant_cnt  (grantCnt)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural model of what the arbiter should be doing, in spec terms.
   int            mPtr;
   bit            mLock;
   int            mOwner;
   bit            mWrEn;
   logic [DW-1:0] mData;
   int            mGid;
   int            mcnt [N];

   // Requester traffic sources and a simple FIFO occupancy model.
   int            rem  [N];
   int            pkts [N];
   int            plen [N];
   bit            hold [N];
   logic [DW-1:0] bd   [N];
   bit            randMode;
   bit            fifoAuto;
   int            occ;
   logic          forceFull;
   logic          forceAfull;
   int            accLog [$];
   int            expq   [$];

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] modelReady();
      logic [N-1:0] r;
      bit           ok;
      bit           found;
      int           k;
      r     = '0;
      found = 1'b0;
      ok    = !fifoFull && !(fifoAfull && mWrEn);
      if (ok) begin
         if (mLock) begin
            if (reqValid[mOwner]) r[mOwner] = 1'b1;
         end else begin
            for (int o = 0; o < N; o++) begin
               k = (mPtr + o) % N;
               if (!found && reqValid[k]) begin
                  r[k]  = 1'b1;
                  found = 1'b1;
               end
            end
         end
      end
      return r;
   endfunction

   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         if (randMode) begin
            if (rem[i] == 0 && ($urandom % 4) == 0) rem[i] = $urandom_range(1, 4);
            if (hold[i] && ($urandom % 2) == 0) hold[i] = 1'b0;
         end
         reqValid[i]         = (rem[i] > 0) && !hold[i];
         reqLast[i]          = (rem[i] == 1);
         reqData[i*DW +: DW] = bd[i];
      end
      if (fifoAuto) begin
         fifoFull  = (occ >= DEPTH);
         fifoAfull = (occ >= DEPTH - 1);
      end else begin
         fifoFull  = forceFull;
         fifoAfull = forceAfull;
      end
   endtask

   task automatic checkOutput();
      logic [N-1:0] er;
      int           k;
      bit           rd;
      @(negedge clk);
      er = modelReady();
      checkVal("req_ready", 32'(reqReady), 32'(er));
      checkVal("wr_en", 32'(wrEn), 32'(mWrEn));
      checkVal("wr_data", 32'(wrData), 32'(mData));
      checkVal("grant_id", 32'(grantId), 32'(mGid));
      checkVal("busy", 32'(busy), 32'(mLock));
      checkVal("wr_en_while_full", 32'(wrEn & fifoFull), 32'd0);
`ifdef FIFO_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) checkVal("grant_cnt", 32'(grantCnt[i*CW +: CW]), 32'(mcnt[i]));
`endif
      k = -1;
      for (int i = 0; i < N; i++) if (er[i]) k = i;
      if (fifoAuto) begin
         rd  = (occ > 0) && (($urandom % 3) != 0);
         occ = occ + (mWrEn ? 1 : 0) - (rd ? 1 : 0);
      end
      if (k >= 0) begin
         accLog.push_back(k);
         mData = bd[k];
         mGid  = k;
         if (reqLast[k]) begin
            mLock = 1'b0;
            mPtr  = (k + 1) % N;
            if (mcnt[k] < SAT) mcnt[k]++;
         end else if (!mLock) begin
            mLock  = 1'b1;
            mOwner = k;
         end
         rem[k]--;
         bd[k] = DW'($urandom);
         if (rem[k] == 0 && pkts[k] > 0) begin
            rem[k] = plen[k];
            pkts[k]--;
         end
         if (randMode) hold[k] = (($urandom % 3) == 0);
      end
      mWrEn = (k >= 0);
      @(posedge clk);
      #1;
   endtask

   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) begin
         applyStimulus();
         checkOutput();
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mPtr   = 0;
      mLock  = 1'b0;
      mOwner = 0;
      mWrEn  = 1'b0;
      mData  = '0;
      mGid   = 0;
      occ    = 0;
      for (int i = 0; i < N; i++) begin
         mcnt[i] = 0;
         rem[i]  = 0;
         pkts[i] = 0;
         plen[i] = 1;
         hold[i] = 1'b0;
         bd[i]   = DW'(8'hA0 + i);
      end
      accLog.delete();
   endtask

   task automatic checkLog(input string tag);
      checkVal({tag, "_count"}, 32'(accLog.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
         if (i < accLog.size()) checkVal({tag, "_order"}, 32'(accLog[i]), 32'(expq[i]));
      end
   endtask

   initial begin
      rst        = 1'b1;
      reqValid   = '0;
      reqLast    = '0;
      reqData    = '0;
      fifoFull   = 1'b0;
      fifoAfull  = 1'b0;
      forceFull  = 1'b0;
      forceAfull = 1'b0;
      randMode   = 1'b0;
      fifoAuto   = 1'b0;
      applyReset();
      runCycles(2);

      // Single-beat packets from 0 and 2 alternate strictly.
      applyReset();
      for (int i = 0; i < N; i += 2) begin
         rem[i]  = 1;
         pkts[i] = 2;
      end
      runCycles(7);
      expq = '{0, 2, 0, 2, 0, 2};
      checkLog("rr_alternate");

      // A 3-beat packet from 1 locks out requester 3 until its last beat.
      applyReset();
      rem[1] = 3;
      rem[3] = 1;
      runCycles(6);
      expq = '{1, 1, 1, 3};
      checkLog("lock_3beat");

      // Owner gap mid-packet: bubbles, requester 0 still blocked.
      applyReset();
      rem[2] = 3;
      runCycles(1);
      hold[2] = 1'b1;
      rem[0]  = 1;
      runCycles(3);
      hold[2] = 1'b0;
      runCycles(5);
      expq = '{2, 2, 2, 0};
      checkLog("lock_gap");

      // Almost-full held: one write every other cycle.
      applyReset();
      forceAfull = 1'b1;
      for (int i = 0; i < N; i++) begin
         rem[i]  = 1;
         pkts[i] = 1;
      end
      runCycles(8);
      checkVal("afull_alternate", 32'(accLog.size()), 32'd4);
      forceAfull = 1'b0;
      runCycles(6);

      // Full held: nothing accepted, then traffic drains once released.
      applyReset();
      forceFull  = 1'b1;
      forceAfull = 1'b1;
      for (int i = 0; i < N; i++) rem[i] = 1;
      runCycles(5);
      checkVal("full_blocks", 32'(accLog.size()), 32'd0);
      forceFull  = 1'b0;
      forceAfull = 1'b0;
      runCycles(6);
      checkVal("full_release", 32'(accLog.size()), 32'd4);

      // Reset on beat 2 of a 4-beat packet abandons it and restores ptr 0.
      applyReset();
      rem[1] = 1;
      runCycles(1);
      rem[1] = 4;
      runCycles(1);
      applyStimulus();
      applyReset();
      rem[0] = 1;
      rem[3] = 1;
      runCycles(4);
      expq = '{0, 3};
      checkLog("reset_midpacket");

`ifdef FIFO_ARB_PERF_CNT_EN
      // Five packets from requester 0 saturate a 2-bit counter at 3.
      applyReset();
      rem[0]  = 1;
      pkts[0] = 4;
      runCycles(7);
      checkVal("cnt_saturate", 32'(grantCnt[0 +: CW]), 32'd3);
`endif

      // Random traffic with a live FIFO occupancy model driving full/afull.
      applyReset();
      randMode = 1'b1;
      fifoAuto = 1'b1;
      runCycles(3000);
      randMode = 1'b0;
      fifoAuto = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
